gun_input_ctl: RTL and testbench

GUN_INPUT_CTL -- requirements
Module: gun_input_ctl

---
 rtl/gun_input_ctl.sv | 168 ++++++++++++++++
 tb/tb_gun_input_ctl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gun_input_ctl.sv
// Light-gun input controller: synchronizes and debounces the trigger, requests a
// highlight frame, samples the photodetector and reports hit or miss per shot.
`timescale 1ns / 1ps

module gun_input_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned SETTLE_FRAMES   = 1,
  parameter int unsigned DETECT_FRAMES   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger_raw_i,
  input  logic photo_raw_i,
  input  logic frame_start_i,
  output logic flash_req_o,
  output logic shot_o,
  output logic hit_o,
  output logic miss_o,
  output logic busy_o
);

  localparam int unsigned DbTarget  = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned DbW       = $clog2(DbTarget + 1);
  localparam int unsigned FrameMax  = (SETTLE_FRAMES > DETECT_FRAMES) ? SETTLE_FRAMES
                                                                      : DETECT_FRAMES;
  localparam int unsigned CntW      = (FrameMax < 1) ? 1 : $clog2(FrameMax + 1);
  localparam logic [CntW-1:0] SettleTgt = CntW'(SETTLE_FRAMES);
  localparam logic [CntW-1:0] DetectTgt = CntW'(DETECT_FRAMES);
  localparam logic [DbW-1:0]  DbLast    = DbW'(DbTarget - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StSettle,
    StSample,
    StReport,
    StRelease
  } state_e;

  state_e          state_q, state_d;
  logic            trig_s1_q, trig_s2_q;
  logic            photo_s1_q, photo_s2_q;
  logic            deb_q, deb_d;
  logic            deb_prev_q;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CntW-1:0] frame_inc;
  logic            hit_flag_q, hit_flag_d;
  logic            flash_q, flash_d;
  logic            shot_q, shot_d;
  logic            deb_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      photo_s1_q  <= 1'b0;
      photo_s2_q  <= 1'b0;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      db_cnt_q    <= '0;
      frame_cnt_q <= '0;
      hit_flag_q  <= 1'b0;
      flash_q     <= 1'b0;
      shot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_s1_q   <= trigger_raw_i;
      trig_s2_q   <= trig_s1_q;
      photo_s1_q  <= photo_raw_i;
      photo_s2_q  <= photo_s1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      db_cnt_q    <= db_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hit_flag_q  <= hit_flag_d;
      flash_q     <= flash_d;
      shot_q      <= shot_d;
    end
  end

  // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (trig_s2_q != deb_q) begin
      if (db_cnt_q == DbLast) begin
        deb_d = trig_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign deb_rise  = deb_q & ~deb_prev_q;
  assign frame_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hit_flag_d  = hit_flag_q;
    flash_d     = flash_q;
    shot_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (deb_rise) begin
          shot_d  = 1'b1;
          state_d = StWaitFrame;
        end
      end
      StWaitFrame: begin
        // A frame_start coincident with the shot pulse belongs to the old frame.
        if (frame_start_i && !shot_q) begin
          flash_d     = 1'b1;
          frame_cnt_d = '0;
          if (SETTLE_FRAMES == 0) begin
            hit_flag_d = 1'b0;
            state_d    = StSample;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (frame_start_i) begin
          if (frame_inc >= SettleTgt) begin
            frame_cnt_d = '0;
            hit_flag_d  = 1'b0;
            state_d     = StSample;
          end else begin
            frame_cnt_d = frame_inc;
          end
        end
      end
      StSample: begin
        if (frame_start_i && (frame_inc >= DetectTgt)) begin
          state_d = StReport;
        end else begin
          if (frame_start_i) begin
            frame_cnt_d = frame_inc;
          end
          if (photo_s2_q) begin
            hit_flag_d = 1'b1;
          end
        end
      end
      StReport: begin
        flash_d     = 1'b0;
        frame_cnt_d = '0;
        state_d     = StRelease;
      end
      StRelease: begin
        if (!deb_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign flash_req_o = flash_q;
  assign shot_o      = shot_q;
  assign hit_o       = (state_q == StReport) && hit_flag_q;
  assign miss_o      = (state_q == StReport) && !hit_flag_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_gun_input_ctl.sv
// Bench for gun_input_ctl: randomized shots checked against event times derived
// from trigger/frame/photo timing arithmetic.
`timescale 1ns / 1ps

module tb_gun_input_ctl;

  logic clk = 1'b0;
  logic rst_n;
  logic trigger_raw_i = 1'b0;
  logic photo_raw_i = 1'b0;
  logic frame_start_i = 1'b0;
  logic flash_req_o, shot_o, hit_o, miss_o, busy_o;

  gun_input_ctl #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_FRAMES  (1),
    .DETECT_FRAMES  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger_raw_i(trigger_raw_i),
    .photo_raw_i  (photo_raw_i),
    .frame_start_i(frame_start_i),
    .flash_req_o  (flash_req_o),
    .shot_o       (shot_o),
    .hit_o        (hit_o),
    .miss_o       (miss_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int shot_cnt = 0, hit_cnt = 0, miss_cnt = 0, busy_hi = 0;
  int shot_cyc = -1, hm_cyc = -1, flash_rise = -1, flash_fall = -1, busy_fall = -1;
  bit excl_err = 1'b0, flash_prev = 1'b0, busy_prev = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle k is the interval after rising edge k; inputs set in cycle k are seen at edge k+1.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    frame_start_i = (cyc % 100 == 0);
    if (shot_o) begin shot_cnt++; shot_cyc = cyc; end
    if (hit_o) begin hit_cnt++; hm_cyc = cyc; end
    if (miss_o) begin miss_cnt++; hm_cyc = cyc; end
    if (hit_o && miss_o) excl_err = 1'b1;
    if (flash_req_o && !flash_prev) flash_rise = cyc;
    if (!flash_req_o && flash_prev) flash_fall = cyc;
    if (!busy_o && busy_prev) busy_fall = cyc;
    if (busy_o) busy_hi++;
    flash_prev = flash_req_o;
    busy_prev  = busy_o;
  endtask

  // mode: 0 = no light, 1 = light in the sample frame, 2 = light in the settle frame.
  task automatic do_shot(input int hold, input int mode, input bit extra, input bit preheld,
                         input string nm);
    int t, s, f0, r, poff, plen, s0, h0, m0, end_c, exp_bf;
    if (!preheld) begin
      repeat ($urandom_range(20, 119)) tick();
      trigger_raw_i = 1'b1;
    end
    t    = cyc;
    s    = t + 7;
    f0   = ((s + 1 + 99) / 100) * 100;
    r    = t + hold;
    poff = (mode == 1) ? int'($urandom_range(105, 185)) : int'($urandom_range(5, 85));
    plen = $urandom_range(1, 10);
    s0 = shot_cnt; h0 = hit_cnt; m0 = miss_cnt;
    shot_cyc = -1; hm_cyc = -1; flash_rise = -1; flash_fall = -1; busy_fall = -1;
    exp_bf = (f0 + 203 > r + 7) ? f0 + 203 : r + 7;
    end_c  = (f0 + 260 > r + 30) ? f0 + 260 : r + 30;
    while (cyc < end_c) begin
      tick();
      if (cyc == r) trigger_raw_i = 1'b0;
      if (extra && cyc == f0 + 30) trigger_raw_i = 1'b1;
      if (extra && cyc == f0 + 60) trigger_raw_i = 1'b0;
      photo_raw_i = (mode != 0) && (cyc >= f0 + poff) && (cyc < f0 + poff + plen);
    end
    photo_raw_i = 1'b0;
    check({nm, "_shot_count"}, shot_cnt - s0, 1);
    check({nm, "_shot_cycle"}, shot_cyc, s);
    check({nm, "_flash_rise"}, flash_rise, f0 + 1);
    check({nm, "_flash_fall"}, flash_fall, f0 + 202);
    check({nm, "_hit_count"}, hit_cnt - h0, (mode == 1) ? 1 : 0);
    check({nm, "_miss_count"}, miss_cnt - m0, (mode == 1) ? 0 : 1);
    check({nm, "_report_cycle"}, hm_cyc, f0 + 201);
    check({nm, "_busy_fall"}, busy_fall, exp_bf);
  endtask

  initial begin
    int b0, h0, m0, t, s, f0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_flash", flash_req_o, 0);
    check("rst_shot", shot_o, 0);
    check("rst_hit", hit_o, 0);
    check("rst_miss", miss_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    repeat (10) tick();

    // Trigger bounce never holds a level for 4 synchronized cycles.
    b0 = shot_cnt;
    busy_hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      trigger_raw_i = (((i >> 1) & 1) == 0);
    end
    trigger_raw_i = 1'b0;
    repeat (100) tick();
    check("bounce_shots", shot_cnt - b0, 0);
    check("bounce_busy", busy_hi, 0);

    do_shot(30, 1, 1'b0, 1'b0, "hit");
    do_shot(30, 0, 1'b0, 1'b0, "miss");
    do_shot(500, int'($urandom_range(0, 1)), 1'b0, 1'b0, "held");
    do_shot(30, 2, 1'b0, 1'b0, "settle_photo");
    do_shot(30, 1, 1'b1, 1'b0, "extra_press");
    for (int k = 0; k < 3; k++) begin
      do_shot(int'($urandom_range(20, 400)), int'($urandom_range(0, 2)), 1'b0, 1'b0, "rand");
    end

    // Reset in the middle of the sample frame, trigger kept held through it.
    repeat ($urandom_range(20, 119)) tick();
    trigger_raw_i = 1'b1;
    t  = cyc;
    s  = t + 7;
    f0 = ((s + 1 + 99) / 100) * 100;
    while (cyc < f0 + 150) begin
      tick();
      photo_raw_i = (cyc >= f0 + 120) && (cyc < f0 + 130);
    end
    check("pre_reset_flash", flash_req_o, 1);
    h0 = hit_cnt;
    m0 = miss_cnt;
    #3 rst_n = 1'b0;
    #1;
    check("reset_flash_async", flash_req_o, 0);
    check("reset_busy_async", busy_o, 0);
    photo_raw_i = 1'b0;
    repeat (250) tick();
    check("reset_no_hit", hit_cnt - h0, 0);
    check("reset_no_miss", miss_cnt - m0, 0);
    rst_n = 1'b1;
    do_shot(30, 1, 1'b0, 1'b1, "post_reset");

    check("hit_miss_exclusive", excl_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
